hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
// - Parametrised forwarding/interlock unit for the pipelined CPU; successor to the fixed EX/MEM bypass logic.
// - Keeps its own shift register of destination tags for in-flight instructions past ID.
// - Drives per-source bypass selects and a load-use stall, with configurable bypass depth and load latency.
// - Sits beside the ID stage; selects drive the ID operand muxes.
// PARAMETERS
// - REG_AW      5  register-index width (2**REG_AW architectural registers)
// - DEPTH       2  in-flight stages tracked and bypassable (stage 1 = EX, stage 2 = MEM, ...)
// - LOAD_RDY    2  first stage index at which load data is forwardable (1..DEPTH)
// - SEL_W       $clog2(DEPTH+1)  width of bypass selects
// PORTS
// - clk          in   1       clock, rising edge
// - rst_n        in   1       asynchronous active-low reset
// - id_valid     in   1       ID holds a real instruction
// - id_r1        in   REG_AW  source register 1
// - id_r2        in   REG_AW  source register 2
// - id_use_r1    in   1       instruction actually reads r1
// - id_use_r2    in   1       instruction reads r2 (ALU-reg, store data, mtc0)
// - id_rw        in   REG_AW  destination register
// - id_we        in   1       instruction writes id_rw
// - id_load      in   1       instruction is a load
// - flush        in   1       kill the ID instruction (branch/exception)
// - stall        out  1       hold IF/ID; a bubble enters stage 1
// - fwd_sel_r1   out  SEL_W   0 = register file; k = bypass from stage k
// - fwd_sel_r2   out  SEL_W   same, for r2
// - stall_cycles out  32      (only with HAZ_STATS_EN) count of stall cycles
// BEHAVIOUR
// - State: DEPTH entries {vld, rw, ld}. At reset all vld = 0, so stall = 0 and both selects = 0.
// - Every clock edge, entry k takes entry k-1 for k = 2..DEPTH. The oldest entry retires.
// - Entry 1 captures {id_valid & id_we & ~stall & ~flush & (id_rw != 0), id_rw, id_load}; otherwise a bubble (vld = 0).
// - Match for source s at stage k: entry k vld, entry k rw == id_rs, id_use_s, id_rs != 0.
//   - Register 0 never matches.
// - Source s picks the lowest matching k (youngest producer wins). With no match, sel = 0.
// - Load-use: the chosen entry has ld and k < LOAD_RDY. Then stall = id_valid & ~flush and that sel is forced to 0.
//   - With LOAD_RDY = 2, a load in EX stalls one cycle. With LOAD_RDY = 3 it stalls two cycles, and the load then bypasses from stage 3.
// - Selects and stall are combinational from ID inputs and registered state; zero-cycle latency.
// - Stall repeats every cycle until the load reaches LOAD_RDY. There is no FSM beyond the tag pipeline, and no deadlock is possible.
// - flush and stall in the same cycle: flush wins, stall = 0, bubble enters.
// - Reset asserted mid-stall clears all entries immediately; stall drops asynchronously.
// - A producer that leaves stage DEPTH is assumed written back, so regfile read (sel = 0) is correct.
// CONFIGURATION
// - HAZ_STATS_EN defined:
//   - stall_cycles port exists; it increments on each clk with stall = 1 and saturates at 32'hFFFF_FFFF.
//   - It resets to 0.
// - HAZ_STATS_EN undefined: no port, no counter. Stall/select behaviour is identical.
// STRUCTURE
// - Package haz_pkg holds:
//   - typedef haz_tag_t {logic vld; logic [REG_AW-1:0] rw; logic ld;}
//   - localparam FWD_RF = 0
// - Sub-module haz_tag_stage: one entry register with async reset and bubble/flush gating, generated DEPTH times.
// - Top level holds the priority match encoders (one per source), the stall logic and the optional counter.
// TESTING
// - Reset: rst_n low with random ID inputs -> stall = 0 and fwd_sel_r1 = fwd_sel_r2 = 0. Deassert -> state stays empty.
// - ALU chain: add r3 then sub r4 = r3 + r3 -> fwd_sel_r1 = fwd_sel_r2 = 1, stall = 0. The next instruction reading r3 gets sel = 2.
// - Load-use (LOAD_RDY = 2): lw r5, then add reading r5 ->
//   - stall = 1 for exactly one cycle, then sel_r1 = 2.
//   - With LOAD_RDY = 3: two stall cycles, then sel = 3.
// - Youngest wins: r7 written by the instructions in stage 2 and stage 1 -> sel = 1. Write to r0 followed by a read of r0 -> sel = 0.
// - Flush: lw r5 in stage 1, ID reads r5 with flush = 1 -> stall = 0 and stage 1 gets a bubble.
//   - Next cycle, an unrelated instruction sees no match.
// - HAZ_STATS_EN: 3 load-use events at LOAD_RDY = 3 -> stall_cycles = 6. Async reset mid-run -> stall_cycles = 0.

Source files
------------

// File: rtl/haz_pkg.sv
// rtl/haz_pkg.sv - shared types and constants for the hazard scoreboard
// Purpose: destination-tag entry type and the register-file select encoding.
// Ports: none (package).
// TAG_AW is the widest register index a tag can hold; REG_AW of the top
// must not exceed it (narrower indices are zero-extended into the tag).
package haz_pkg;

  localparam int TAG_AW = 8;
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic              vld;
    logic [TAG_AW-1:0] rw;
    logic              ld;
  } haz_tag_t;

endpackage

// File: rtl/haz_tag_stage.sv
// rtl/haz_tag_stage.sv - one in-flight destination-tag register
// Purpose: holds the {vld, rw, ld} tag of one pipeline stage past ID.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, clears the entry
//   d      in   tag from the younger neighbour (or the ID capture)
//   kill   in   load a bubble instead of d (stall/flush gating)
//   q      out  registered tag
module haz_tag_stage
  import haz_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  haz_tag_t d,
  input  logic     kill,
  output haz_tag_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
      if (kill) q.vld <= 1'b0;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - forwarding select and load-use interlock unit
// Purpose: tracks destination tags of in-flight instructions and drives the
//   ID operand bypass selects and the load-use stall (zero-cycle latency).
// Optional feature: define HAZ_STATS_EN to add the saturating stall_cycles
//   counter port.
// Ports:
//   clk, rst_n          clock (rising) and asynchronous active-low reset
//   id_valid            ID holds a real instruction
//   id_r1, id_r2        source register indices
//   id_use_r1/_r2       instruction actually reads that source
//   id_rw, id_we        destination register and its write enable
//   id_load             instruction is a load
//   flush               kill the ID instruction
//   stall               hold IF/ID, bubble enters stage 1
//   fwd_sel_r1/_r2      0 = register file, k = bypass from stage k
//   stall_cycles        stall cycle count (HAZ_STATS_EN only)
module hazard_scoreboard
  import haz_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 2,
  parameter int LOAD_RDY = 2,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_r1,
  input  logic [REG_AW-1:0] id_r2,
  input  logic              id_use_r1,
  input  logic              id_use_r2,
  input  logic [REG_AW-1:0] id_rw,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_sel_r1,
  output logic [SEL_W-1:0]  fwd_sel_r2
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  haz_tag_t tag_d [1:DEPTH];
  haz_tag_t tag_q [1:DEPTH];
  logic     kill  [1:DEPTH];

  // Stage 1 takes the ID instruction unless it stalls, is flushed or writes r0;
  // older stages shift unconditionally and the oldest simply drops off.
  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    if (k == 1) begin : g_head
      assign tag_d[k].vld = id_valid & id_we & (id_rw != '0);
      assign tag_d[k].rw  = TAG_AW'(id_rw);
      assign tag_d[k].ld  = id_load;
      assign kill[k]      = stall | flush;
    end else begin : g_tail
      assign tag_d[k] = tag_q[k-1];
      assign kill[k]  = 1'b0;
    end
    haz_tag_stage u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (tag_d[k]),
      .kill (kill[k]),
      .q    (tag_q[k])
    );
  end

  logic [SEL_W-1:0] sel_r1, sel_r2;
  logic             ld_r1, ld_r2, lu_r1, lu_r2;

  always_comb begin
    sel_r1 = SEL_W'(FWD_RF);
    sel_r2 = SEL_W'(FWD_RF);
    ld_r1  = 1'b0;
    ld_r2  = 1'b0;
    // Scan oldest to youngest so the youngest matching producer overrides.
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_use_r1 && (id_r1 != '0) && tag_q[k].vld && (tag_q[k].rw == TAG_AW'(id_r1))) begin
        sel_r1 = SEL_W'(k);
        ld_r1  = tag_q[k].ld;
      end
      if (id_use_r2 && (id_r2 != '0) && tag_q[k].vld && (tag_q[k].rw == TAG_AW'(id_r2))) begin
        sel_r2 = SEL_W'(k);
        ld_r2  = tag_q[k].ld;
      end
    end
    // A load is only forwardable once it has reached stage LOAD_RDY.
    lu_r1      = ld_r1 && (int'(sel_r1) < LOAD_RDY);
    lu_r2      = ld_r2 && (int'(sel_r2) < LOAD_RDY);
    stall      = id_valid & ~flush & (lu_r1 | lu_r2);
    fwd_sel_r1 = lu_r1 ? SEL_W'(FWD_RF) : sel_r1;
    fwd_sel_r2 = lu_r2 ? SEL_W'(FWD_RF) : sel_r2;
  end

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard (two configurations)
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n     [2];
  logic       id_valid  [2];
  logic [4:0] id_r1     [2];
  logic [4:0] id_r2     [2];
  logic       id_use_r1 [2];
  logic       id_use_r2 [2];
  logic [4:0] id_rw     [2];
  logic       id_we     [2];
  logic       id_load   [2];
  logic       flush     [2];
  logic       stall     [2];
  logic [1:0] sel1      [2];
  logic [1:0] sel2      [2];
`ifdef HAZ_STATS_EN
  logic [31:0] scyc     [2];
`endif

  always #5 clk = ~clk;

  // dut 0: DEPTH 2, LOAD_RDY 2 ; dut 1: DEPTH 3, LOAD_RDY 3
  hazard_scoreboard #(.REG_AW(5), .DEPTH(2), .LOAD_RDY(2)) u_a (
    .clk(clk), .rst_n(rst_n[0]), .id_valid(id_valid[0]), .id_r1(id_r1[0]), .id_r2(id_r2[0]),
    .id_use_r1(id_use_r1[0]), .id_use_r2(id_use_r2[0]), .id_rw(id_rw[0]), .id_we(id_we[0]),
    .id_load(id_load[0]), .flush(flush[0]), .stall(stall[0]), .fwd_sel_r1(sel1[0]), .fwd_sel_r2(sel2[0])
`ifdef HAZ_STATS_EN
    , .stall_cycles(scyc[0])
`endif
  );

  hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .LOAD_RDY(3)) u_b (
    .clk(clk), .rst_n(rst_n[1]), .id_valid(id_valid[1]), .id_r1(id_r1[1]), .id_r2(id_r2[1]),
    .id_use_r1(id_use_r1[1]), .id_use_r2(id_use_r2[1]), .id_rw(id_rw[1]), .id_we(id_we[1]),
    .id_load(id_load[1]), .flush(flush[1]), .stall(stall[1]), .fwd_sel_r1(sel1[1]), .fwd_sel_r2(sel2[1])
`ifdef HAZ_STATS_EN
    , .stall_cycles(scyc[1])
`endif
  );

  typedef struct {
    int    dut;
    bit    stall;
    int    s1;
    int    s2;
    bit    chk_cnt;
    int    cnt;
    string name;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Monitor: every negedge, check everything the stimulus queued this cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (stall[e.dut] !== e.stall) begin
        miscompares++;
        $display("FAIL %s dut%0d stall got %0b want %0b", e.name, e.dut, stall[e.dut], e.stall);
      end
      if (int'(sel1[e.dut]) != e.s1 || $isunknown(sel1[e.dut])) begin
        miscompares++;
        $display("FAIL %s dut%0d fwd_sel_r1 got %0d want %0d", e.name, e.dut, sel1[e.dut], e.s1);
      end
      if (int'(sel2[e.dut]) != e.s2 || $isunknown(sel2[e.dut])) begin
        miscompares++;
        $display("FAIL %s dut%0d fwd_sel_r2 got %0d want %0d", e.name, e.dut, sel2[e.dut], e.s2);
      end
`ifdef HAZ_STATS_EN
      if (e.chk_cnt && (scyc[e.dut] !== 32'(e.cnt))) begin
        miscompares++;
        $display("FAIL %s dut%0d stall_cycles got %0d want %0d", e.name, e.dut, scyc[e.dut], e.cnt);
      end
`endif
    end
  end

  function automatic exp_t mk(input int d, input bit es, input int e1, input int e2,
                              input string nm, input bit cc, input int ec);
    exp_t e;
    e.dut = d; e.stall = es; e.s1 = e1; e.s2 = e2; e.chk_cnt = cc; e.cnt = ec; e.name = nm;
    return e;
  endfunction

  // One ID cycle on dut d (other dut idles), with its expected outputs.
  task automatic step(input int d, input bit rst, input bit v,
                      input int r1, input bit u1, input int r2, input bit u2,
                      input int rw, input bit we, input bit ld, input bit fl,
                      input bit es, input int e1, input int e2, input string nm,
                      input bit cc = 1'b0, input int ec = 0);
    @(posedge clk);
    #1;
    id_valid[1-d] = 1'b0; id_use_r1[1-d] = 1'b0; id_use_r2[1-d] = 1'b0;
    id_we[1-d] = 1'b0; flush[1-d] = 1'b0;
    rst_n[d] = rst;
    id_valid[d] = v; id_r1[d] = 5'(r1); id_use_r1[d] = u1; id_r2[d] = 5'(r2); id_use_r2[d] = u2;
    id_rw[d] = 5'(rw); id_we[d] = we; id_load[d] = ld; flush[d] = fl;
    q.push_back(mk(d, es, e1, e2, nm, cc, ec));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; id_valid[d] = 1'b0; id_r1[d] = '0; id_r2[d] = '0;
      id_use_r1[d] = 1'b0; id_use_r2[d] = 1'b0; id_rw[d] = '0; id_we[d] = 1'b0;
      id_load[d] = 1'b0; flush[d] = 1'b0;
    end
    // Reset with random ID activity: nothing may be flagged.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        id_valid[d] = 1'($urandom); id_r1[d] = 5'($urandom); id_r2[d] = 5'($urandom);
        id_use_r1[d] = 1'($urandom); id_use_r2[d] = 1'($urandom); id_rw[d] = 5'($urandom);
        id_we[d] = 1'($urandom); id_load[d] = 1'($urandom); flush[d] = 1'b0;
        q.push_back(mk(d, 1'b0, 0, 0, "reset", 1'b1, 0));
      end
    end
    // Release reset with an idle ID stage on both.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rel_b");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rel_a");
    step(0, 1, 0, 7, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, "empty_a");

    // dut 0 (DEPTH 2, LOAD_RDY 2)
    step(0, 1, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, "add_r3");
    step(0, 1, 1, 3, 1, 3, 1, 4, 1, 0, 0, 0, 1, 1, "alu_chain");
    step(0, 1, 1, 3, 1, 0, 1, 6, 1, 0, 0, 0, 2, 0, "r3_stage2");
    step(0, 1, 1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, "lw_r5");
    step(0, 1, 1, 5, 1, 6, 1, 8, 1, 0, 0, 1, 0, 2, "load_use");
    step(0, 1, 1, 5, 1, 6, 1, 8, 1, 0, 0, 0, 2, 0, "load_fwd");
    step(0, 1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, "w_r7_a");
    step(0, 1, 1, 7, 1, 0, 0, 7, 1, 0, 0, 0, 1, 0, "w_r7_b");
    step(0, 1, 1, 7, 1, 7, 1, 0, 1, 0, 0, 0, 1, 1, "youngest");
    step(0, 1, 1, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 2, "r0_read");
    step(0, 1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, "lw_r5_f");
    step(0, 1, 1, 5, 1, 0, 0, 9, 1, 0, 1, 0, 0, 0, "flush");
    step(0, 1, 1, 9, 1, 5, 1, 10, 0, 0, 0, 0, 0, 2, "post_flush");
    step(0, 1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, "lw_r5_r");
    step(0, 1, 1, 5, 1, 0, 0, 8, 1, 0, 0, 1, 0, 0, "stall_r");
    step(0, 0, 1, 5, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, "async_rst");
    step(0, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "after_rst");

    // dut 1 (DEPTH 3, LOAD_RDY 3): three load-use events, two stalls each
    for (int n = 1; n <= 3; n++) begin
      step(1, 1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, "b_lw");
      step(1, 1, 1, 5, 1, 2, 1, 8, 1, 0, 0, 1, 0, 0, "b_stall1");
      step(1, 1, 1, 5, 1, 2, 1, 8, 1, 0, 0, 1, 0, 0, "b_stall2");
      step(1, 1, 1, 5, 1, 2, 1, 8, 1, 0, 0, 0, 3, 0, "b_fwd3", 1'b1, 2 * n);
    end
    step(1, 1, 1, 8, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, "b_r8");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "b_rst", 1'b1, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "b_rel", 1'b1, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain queue left %0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
